// File: rtl/cr_fifo_rd_ctrl_pkg.sv
// Shared helpers for the dual-clock FIFO read side: output-buffer occupancy
// encoding and the binary-to-Gray pointer conversion.
package cr_fifo_rd_ctrl_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Wide enough for any pointer; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cr_fifo_rd_ctrl_gray2bin.sv
// Combinational Gray-to-binary decoder; zero latency, no flow control.
module cr_gray2bin #(
  parameter int pWidth = 5
) (
  input  logic [pWidth-1:0] gray_i,
  output logic [pWidth-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    bin_o[pWidth-1] = gray_i[pWidth-1];
    for (int i = pWidth - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/cr_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: issues RAM reads and feeds a 2-entry output buffer.
// WrPtrGray change -> RdEn same cycle -> Valid two cycles later; Ready low stalls reads once the buffer is full.
module cr_fifo_rd_ctrl
  import cr_fifo_rd_ctrl_pkg::*;
#(
  parameter int pAddrWidth = 4,
  parameter int pDataWidth = 8
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [pAddrWidth:0]   WrPtrGray,
  output logic [pAddrWidth:0]   RdPtrGray,
  output logic                  RdEn,
  output logic [pAddrWidth-1:0] RdAddr,
  input  logic [pDataWidth-1:0] RdData,
  output logic [pDataWidth-1:0] Dout,
  output logic                  Valid,
  input  logic                  Ready,
  output logic [pAddrWidth:0]   Level,
  output logic                  Empty
);

  localparam int pPtrWidth = pAddrWidth + 1;
  localparam int pDepth    = 2 ** pAddrWidth;

  if (pAddrWidth < 1) begin : g_bad_width
    $error("cr_fifo_rd_ctrl: pAddrWidth must be at least 1");
  end

  logic [pPtrWidth-1:0]  wr_ptr_bin;
  logic [pPtrWidth-1:0]  avail;
  logic [pPtrWidth-1:0]  rd_ptr_bin_q, rd_ptr_bin_d;
  logic [pPtrWidth-1:0]  rd_ptr_gray_q, rd_ptr_gray_d;
  logic [pPtrWidth-1:0]  level_q, level_d;
  logic                  empty_q;
  logic                  inflight_q;
  logic [1:0]            cnt_q, cnt_d;
  logic [pDataWidth-1:0] buf0_q, buf0_d;
  logic [pDataWidth-1:0] buf1_q, buf1_d;
  logic                  pop;
  logic [2:0]            occ;

  cr_gray2bin #(.pWidth(pPtrWidth)) u_wr_gray2bin (
    .gray_i (WrPtrGray),
    .bin_o  (wr_ptr_bin)
  );

  assign avail = wr_ptr_bin - rd_ptr_bin_q;
  assign pop   = (cnt_q != ST_EMPTY) && Ready;

  // Occupancy the buffer will hold after this edge, counting the read already in flight.
  assign occ  = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign RdEn = (avail != '0) && (occ < 3'd2);

  assign RdAddr    = rd_ptr_bin_q[pAddrWidth-1:0];
  assign RdPtrGray = rd_ptr_gray_q;
  assign Valid     = (cnt_q != ST_EMPTY);
  assign Dout      = buf0_q;
  assign Level     = level_q;
  assign Empty     = empty_q;

  always_comb begin
    rd_ptr_bin_d  = rd_ptr_bin_q;
    rd_ptr_gray_d = rd_ptr_gray_q;
    if (RdEn) begin
      rd_ptr_bin_d  = rd_ptr_bin_q + 1'b1;
      rd_ptr_gray_d = pPtrWidth'(bin2gray(32'(rd_ptr_bin_d)));
    end
  end

  // buf0 is always the head; a capture with count TWO cannot occur without a pop.
  always_comb begin
    cnt_d  = cnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (cnt_q == ST_EMPTY) buf0_d = RdData;
        else                   buf1_d = RdData;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == ST_ONE) begin
          buf0_d = RdData;
        end else begin
          buf0_d = buf1_q;
          buf1_d = RdData;
        end
      end
      default: ;
    endcase
  end

  assign level_d = avail + pPtrWidth'(inflight_q) + pPtrWidth'(cnt_q);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      inflight_q    <= 1'b0;
      cnt_q         <= ST_EMPTY;
      buf0_q        <= '0;
      buf1_q        <= '0;
      level_q       <= '0;
      empty_q       <= 1'b1;
    end else begin
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      inflight_q    <= RdEn;
      cnt_q         <= cnt_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      level_q       <= level_d;
      empty_q       <= (level_d == '0);
    end
  end

  a_avail_le_depth : assert property (@(posedge Clk) disable iff (!Rst_n)
    avail <= pPtrWidth'(pDepth));

endmodule

// File: tb/tb_cr_fifo_rd_ctrl.sv
// Bench for cr_fifo_rd_ctrl: directed write-pointer vectors, registered RAM model, Dout scoreboard.
module tb_cr_fifo_rd_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b1;
  logic [4:0] WrPtrGray = 5'd0;
  logic [4:0] RdPtrGray;
  logic       RdEn;
  logic [3:0] RdAddr;
  logic [7:0] RdData = 8'h00;
  logic [7:0] Dout;
  logic       Valid;
  logic       Ready = 1'b0;
  logic [4:0] Level;
  logic       Empty;

  int         checks = 0;
  int         failures = 0;
  int         rd_issued = 0;
  logic [7:0] exp_q[$];
  logic [4:0] wr_bin = 5'd0;

  cr_fifo_rd_ctrl #(.pAddrWidth(4), .pDataWidth(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .WrPtrGray (WrPtrGray),
    .RdPtrGray (RdPtrGray),
    .RdEn      (RdEn),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .Dout      (Dout),
    .Valid     (Valid),
    .Ready     (Ready),
    .Level     (Level),
    .Empty     (Empty)
  );

  always #5 Clk = ~Clk;

  // RAM contents: RAM[i] = i + 8'h10, one-cycle registered read.
  always @(posedge Clk) if (RdEn) RdData <= 8'h10 + {4'h0, RdAddr};

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted word must match the oldest expected word.
  always @(negedge Clk) begin
    if (Rst_n && Valid && Ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else chk("dout", int'(Dout), int'(exp_q.pop_front()));
    end
  end

  always @(negedge Clk) if (Rst_n && RdEn) rd_issued++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic write_to(input logic [4:0] target);
    while (wr_bin != target) begin
      exp_q.push_back(8'h10 + {4'h0, wr_bin[3:0]});
      wr_bin = wr_bin + 5'd1;
    end
    WrPtrGray = gray(wr_bin);
  endtask

  task automatic do_reset();
    Ready = 1'b0;
    Rst_n = 1'b0;
    wr_bin = 5'd0;
    WrPtrGray = 5'd0;
    exp_q.delete();
    step(2);
    Rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int base;
    int vcnt, first, last, n;
    int addrs[8];
    int exp_addr[4];
    exp_addr = '{14, 15, 0, 1};

    // 1 reset asserted mid-clock, no edge needed
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_valid", Valid, 0);
    chk("rst_rden", RdEn, 0);
    chk("rst_rdptrgray", RdPtrGray, 0);
    chk("rst_level", Level, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_dout", Dout, 0);
    chk("rst_rdaddr", RdAddr, 0);
    step(2);
    Rst_n = 1'b1;
    step(1);

    // 2 single word
    Ready = 1'b1;
    write_to(5'd1);
    #1;
    chk("single_rden", RdEn, 1);
    chk("single_rdaddr", RdAddr, 0);
    step(1);
    chk("single_valid_n1", Valid, 0);
    step(1);
    chk("single_valid_n2", Valid, 1);
    chk("single_dout", Dout, 8'h10);
    chk("single_rdptrgray", RdPtrGray, 5'b00001);
    step(4);
    chk("single_level", Level, 0);
    chk("single_empty", Empty, 1);
    chk("single_sb_left", exp_q.size(), 0);

    // 3 stream of 8
    do_reset();
    Ready = 1'b1;
    base = rd_issued;
    vcnt = 0; first = -1; last = -1;
    write_to(5'd8);
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (Valid) begin
        vcnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_valid_cnt", vcnt, 8);
    chk("stream_no_bubble", last - first + 1, 8);
    chk("stream_reads", rd_issued - base, 8);
    chk("stream_sb_left", exp_q.size(), 0);

    // 4 backpressure
    do_reset();
    base = rd_issued;
    write_to(5'd5);
    step(6);
    chk("bp_reads", rd_issued - base, 2);
    chk("bp_valid", Valid, 1);
    chk("bp_dout", Dout, 8'h10);
    chk("bp_level", Level, 5);
    step(3);
    chk("bp_dout_hold", Dout, 8'h10);
    Ready = 1'b1;
    step(10);
    chk("bp_sb_left", exp_q.size(), 0);
    chk("bp_empty", Empty, 1);

    // 5 pointer wrap
    do_reset();
    Ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      write_to(wr_bin + 5'd1);
      step(1);
    end
    step(5);
    chk("wrap_rdptrgray_30", RdPtrGray, 5'b10001);
    chk("wrap_sb_30", exp_q.size(), 0);
    write_to(wr_bin + 5'd4);
    #1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (RdEn && n < 8) begin
        addrs[n] = int'(RdAddr);
        n++;
      end
      step(1);
    end
    chk("wrap_nreads", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_rdaddr%0d", i), addrs[i], exp_addr[i]);
    step(4);
    chk("wrap_rdptrgray_34", RdPtrGray, 5'b00011);
    chk("wrap_sb_left", exp_q.size(), 0);

    // 6 full FIFO
    do_reset();
    base = rd_issued;
    write_to(5'd16);
    step(6);
    chk("full_level", Level, 16);
    chk("full_reads", rd_issued - base, 2);
    chk("full_empty", Empty, 0);
    Ready = 1'b1;
    step(25);
    chk("full_drain_empty", Empty, 1);
    chk("full_drain_level", Level, 0);
    chk("full_sb_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
